// File: rtl/eco32f_scoreboard.sv
// Register-file scoreboard for the decode stage.
// Per-register countdown counters cover fixed-latency producers (load, mul).
// A per-register pending bit plus a single busy flag covers the variable-latency
// divider, which reports completion through div_done.
module eco32f_scoreboard #(
    parameter int unsigned NREGS    = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned CNT_W    = 3,
    parameter int unsigned LAT_LOAD = 1,
    parameter int unsigned LAT_MUL  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_stall,
    input  logic [AW-1:0]    id_rf_x_addr,
    input  logic             id_rf_x_used,
    input  logic [AW-1:0]    id_rf_y_addr,
    input  logic             id_rf_y_used,
    input  logic [AW-1:0]    id_rf_r_addr,
    input  logic             id_rf_r_we,
    input  logic [1:0]       id_op_class,
    input  logic             div_done,
    input  logic [AW-1:0]    div_rf_r_addr,
    input  logic             flush,
    output logic             id_bubble,
    output logic             id_issue,
    output logic             div_busy,
    output logic [NREGS-1:0] sb_pending
);

    localparam logic [1:0] OpAlu  = 2'd0;
    localparam logic [1:0] OpLoad = 2'd1;
    localparam logic [1:0] OpMul  = 2'd2;
    localparam logic [1:0] OpDiv  = 2'd3;

    // Reject parameter sets the counters cannot represent.
    generate
        if (LAT_LOAD < 1 || LAT_LOAD > (2 ** CNT_W) - 1) begin : g_bad_lat_load
            $error("eco32f_scoreboard: LAT_LOAD out of range for CNT_W");
        end
        if (LAT_MUL < 1 || LAT_MUL > (2 ** CNT_W) - 1) begin : g_bad_lat_mul
            $error("eco32f_scoreboard: LAT_MUL out of range for CNT_W");
        end
        if (NREGS != 2 ** AW) begin : g_bad_nregs
            $error("eco32f_scoreboard: NREGS must equal 2**AW");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt [NREGS];
    logic [NREGS-1:0] r_div_pend;
    logic             r_div_busy;

    logic [CNT_W-1:0] w_cnt_nxt [NREGS];
    logic [NREGS-1:0] w_div_pend_nxt;
    logic             w_div_busy_nxt;
    logic [NREGS-1:0] w_busy;
    logic             w_hazard;

    // Busy vector from registered state only; r0 is never busy.
    always_comb begin
        w_busy = '0;
        for (int i = 1; i < NREGS; i++) begin
            w_busy[i] = (r_cnt[i] != '0) | r_div_pend[i];
        end
    end

    // RAW, WAW and divider structural hazards drive the bubble.
    always_comb begin
        w_hazard  = (id_rf_x_used & w_busy[id_rf_x_addr])
                  | (id_rf_y_used & w_busy[id_rf_y_addr])
                  | (id_rf_r_we   & w_busy[id_rf_r_addr])
                  | ((id_op_class == OpDiv) & r_div_busy);
        id_bubble  = id_valid & ~flush & w_hazard;
        id_issue   = id_valid & ~id_stall & ~id_bubble & ~flush;
        div_busy   = r_div_busy;
        sb_pending = w_busy;
    end

    // Next-state: flush wins, then decrement, div completion, and issue (issue overrides).
    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_div_pend_nxt = r_div_pend;
        w_div_busy_nxt = r_div_busy;
        if (flush) begin
            for (int i = 0; i < NREGS; i++) begin
                w_cnt_nxt[i] = '0;
            end
            w_div_pend_nxt = '0;
            w_div_busy_nxt = 1'b0;
        end else begin
            // Bubbles still advance the pipeline, so only a stall freezes counters.
            if (!id_stall) begin
                for (int i = 0; i < NREGS; i++) begin
                    if (r_cnt[i] != '0) begin
                        w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
                    end
                end
            end
            if (div_done) begin
                w_div_pend_nxt[div_rf_r_addr] = 1'b0;
                w_div_busy_nxt                = 1'b0;
            end
            if (id_issue && id_rf_r_we && (id_rf_r_addr != '0)) begin
                unique case (id_op_class)
                    OpLoad: w_cnt_nxt[id_rf_r_addr] = CNT_W'(LAT_LOAD);
                    OpMul:  w_cnt_nxt[id_rf_r_addr] = CNT_W'(LAT_MUL);
                    OpDiv: begin
                        w_div_pend_nxt[id_rf_r_addr] = 1'b1;
                        w_div_busy_nxt               = 1'b1;
                    end
                    OpAlu:  ;
                    default: ;
                endcase
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_cnt[i] <= '0;
            end
            r_div_pend <= '0;
            r_div_busy <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_div_pend <= w_div_pend_nxt;
            r_div_busy <= w_div_busy_nxt;
        end
    end

endmodule
